puf_sig_req_scheduler: RTL and testbench
========================================

Name: puf_sig_req_scheduler

Overview:
- Round-robin scheduler sharing one PUF signature engine (SRAM address generator + ECC decoder) among NUM_REQ requesters.
- Accepts a challenge address and helper data from the winning requester, then drives the engine's load/en protocol: load address, run, wait for done, clear.
- Returns the corrected signature, or a timeout error, on a single response channel tagged with the requester ID.
- Sits between the security/authentication fabric and the PUF IP.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- CHALLENGE_SIZE, 32, challenge/start address width.
- SIGN_SIZE, 256, signature width.
- HELPER_DATA_SIZE, 96, ECC helper data width.
- TIMEOUT_CYCLES, 1024, maximum RUN cycles before abort (≥2).
- CLEAR_CYCLES, 2, minimum cycles with load=0/en=0 between jobs (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_addr  in  NUM_REQ*CHALLENGE_SIZE  packed challenges; requester i at [i*CHALLENGE_SIZE +: CHALLENGE_SIZE]
- req_helper  in  NUM_REQ*HELPER_DATA_SIZE  packed helper data, same packing
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  $clog2(NUM_REQ)  requester index of the response
- rsp_sig  out  SIGN_SIZE  corrected signature; 0 when rsp_err=1
- rsp_err  out  1  1 = engine timeout
- eng_addr  out  CHALLENGE_SIZE  engine start address
- eng_helper  out  HELPER_DATA_SIZE  engine helper data
- eng_load  out  1  engine load
- eng_en  out  1  engine enable
- eng_done  in  1  engine completion (level)
- eng_sig  in  SIGN_SIZE  engine corrected signature
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0: req_ready, rsp_valid, rsp_id, rsp_sig, rsp_err, eng_addr, eng_helper, eng_load, eng_en, busy.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, LOAD, RUN, RESP, CLEAR.
  - IDLE:
    - Winner = first i with req_valid[i]=1, searching last+1, last+2, … modulo NUM_REQ.
    - req_ready[winner]=1 combinationally in IDLE only; all other req_ready bits 0.
    - On valid&ready: latch winner index, req_addr slice into eng_addr, req_helper slice into eng_helper; last <= winner; go to LOAD.
    - No valid: stay in IDLE.
  - LOAD: exactly 1 cycle with eng_load=1, eng_en=0; then RUN.
  - RUN:
    - eng_load=1, eng_en=1; timeout counter increments from 0.
    - First cycle eng_done=1 is sampled: rsp_sig <= eng_sig, rsp_err <= 0; go to RESP.
    - Counter reaches TIMEOUT_CYCLES-1 with eng_done=0: rsp_sig <= 0, rsp_err <= 1; go to RESP.
    - eng_done and timeout in the same cycle: done wins.
  - RESP:
    - eng_load=1, eng_en=0, so the engine holds its result and does not advance.
    - rsp_valid=1; rsp_id, rsp_sig, rsp_err held stable until rsp_ready=1.
    - On rsp_valid&rsp_ready: rsp_valid <= 0; go to CLEAR.
  - CLEAR:
    - eng_load=0, eng_en=0 (engine internal counters reset).
    - Stay at least CLEAR_CYCLES cycles, and additionally until eng_done=0; then IDLE.
    - This state has no timeout.
- Arbitration rules:
  - eng_addr and eng_helper change only on IDLE acceptance.
  - Requests arriving while busy wait; they are never dropped and req_ready stays 0.
  - A requester may deassert req_valid before acceptance with no effect.
- Latency: acceptance to rsp_valid = 1 (LOAD) + N RUN cycles + 1 registered cycle, where N = cycles until eng_done is sampled high.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values, pointer restored; any in-flight job is lost with no response.
- Counters: the timeout counter is $clog2(TIMEOUT_CYCLES)+1 bits and is cleared on entry to RUN. The clear counter is cleared on entry to CLEAR.

Test Plan:
- Single request: req_valid=4'b0001, addr=0x10, eng_done driven 40 cycles after RUN entry with eng_sig=256'hA5…A5 -> req_ready[0] one cycle; LOAD 1 cycle; rsp_valid with rsp_id=0, rsp_sig=A5…A5, rsp_err=0; CLEAR ≥2 cycles; busy=0 after.
- Round-robin fairness: all four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; no requester granted twice before the others are served.
- Timeout: eng_done held 0, TIMEOUT_CYCLES=16 -> rsp_valid after 16 RUN cycles with rsp_err=1, rsp_sig=0; next request still served normally.
- Response backpressure: rsp_ready=0 for 10 cycles -> rsp_valid, rsp_id, rsp_sig stable; eng_en=0 and eng_load=1 throughout; no new grant; CLEAR entered only after rsp_ready=1.
- Sticky done: eng_done stays 1 for 5 cycles after CLEAR entry -> CLEAR lasts 5 cycles, not 2; no re-grant until eng_done=0.
- Async reset in RUN: rst pulsed mid-job -> all outputs 0 immediately; after release, requester 0 wins over requester 2 when both valid.

Source files
------------

// File: rtl/puf_sig_req_scheduler.sv
// Round-robin scheduler that time-shares one PUF signature engine among NUM_REQ
// requesters and returns the corrected signature (or a timeout error) tagged with the requester ID.
module puf_sig_req_scheduler #(
  parameter int NUM_REQ          = 4,
  parameter int CHALLENGE_SIZE   = 32,
  parameter int SIGN_SIZE        = 256,
  parameter int HELPER_DATA_SIZE = 96,
  parameter int TIMEOUT_CYCLES   = 1024,
  parameter int CLEAR_CYCLES     = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ*CHALLENGE_SIZE-1:0]      req_addr,
  input  logic [NUM_REQ*HELPER_DATA_SIZE-1:0]    req_helper,
  output logic                                   rsp_valid,
  input  logic                                   rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]             rsp_id,
  output logic [SIGN_SIZE-1:0]                   rsp_sig,
  output logic                                   rsp_err,
  output logic [CHALLENGE_SIZE-1:0]              eng_addr,
  output logic [HELPER_DATA_SIZE-1:0]            eng_helper,
  output logic                                   eng_load,
  output logic                                   eng_en,
  input  logic                                   eng_done,
  input  logic [SIGN_SIZE-1:0]                   eng_sig,
  output logic                                   busy
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int CCNT_W = $clog2(CLEAR_CYCLES) + 1;
  localparam logic [TCNT_W-1:0] TLAST = TCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CCNT_W-1:0] CLAST = CCNT_W'(CLEAR_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, RESP, CLEAR} state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     last;
  logic [ID_W-1:0]     win;
  logic                found;
  logic [TCNT_W-1:0]   tcnt;
  logic [CCNT_W-1:0]   ccnt;

  // Lowest valid index above the pointer wins; otherwise wrap to the lowest valid index.
  always_comb begin
    win   = '0;
    found = |req_valid;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_valid[i]) win = ID_W'(i);
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_valid[i] && (ID_W'(i) > last)) win = ID_W'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    eng_load  = 1'b0;
    eng_en    = 1'b0;
    rsp_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        // Gated by rst so the grant reads 0 while reset is held.
        if (found && !rst) req_ready = NUM_REQ'(1) << win;
        if (found) state_nxt = LOAD;
      end
      LOAD: begin
        eng_load  = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        eng_load = 1'b1;
        eng_en   = 1'b1;
        if (eng_done || (tcnt == TLAST)) state_nxt = RESP;
      end
      RESP: begin
        eng_load  = 1'b1;
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = CLEAR;
      end
      CLEAR: begin
        if ((ccnt == CLAST) && !eng_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last       <= ID_W'(NUM_REQ - 1);
      rsp_id     <= '0;
      eng_addr   <= '0;
      eng_helper <= '0;
      rsp_sig    <= '0;
      rsp_err    <= 1'b0;
      tcnt       <= '0;
      ccnt       <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          rsp_id     <= win;
          last       <= win;
          eng_addr   <= req_addr[win*CHALLENGE_SIZE +: CHALLENGE_SIZE];
          eng_helper <= req_helper[win*HELPER_DATA_SIZE +: HELPER_DATA_SIZE];
        end
        LOAD: tcnt <= '0;
        RUN: begin
          tcnt <= tcnt + 1'b1;
          // Done has priority over a coincident timeout.
          if (eng_done) begin
            rsp_sig <= eng_sig;
            rsp_err <= 1'b0;
          end else if (tcnt == TLAST) begin
            rsp_sig <= '0;
            rsp_err <= 1'b1;
          end
        end
        RESP: if (rsp_ready) ccnt <= '0;
        CLEAR: if (ccnt != CLAST) ccnt <= ccnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_sig_req_scheduler.sv
// Directed bench for puf_sig_req_scheduler: grant order, normal/timeout jobs,
// response backpressure, sticky done in CLEAR and asynchronous reset mid-job.
module tb_puf_sig_req_scheduler;

  localparam int NR = 4;
  localparam int CS = 32;
  localparam int SS = 256;
  localparam int HS = 96;
  localparam int TO = 64;
  localparam int CC = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*CS-1:0]  req_addr;
  logic [NR*HS-1:0]  req_helper;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [SS-1:0]     rsp_sig;
  logic              rsp_err;
  logic [CS-1:0]     eng_addr;
  logic [HS-1:0]     eng_helper;
  logic              eng_load;
  logic              eng_en;
  logic              eng_done;
  logic [SS-1:0]     eng_sig;
  logic              busy;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [SS-1:0] SIG_A = {8{32'hA5A5_A5A5}};
  localparam logic [SS-1:0] SIG_B = {8{32'h1234_5678}};
  localparam logic [SS-1:0] SIG_C = {8{32'hC0DE_F00D}};
  localparam logic [SS-1:0] SIG_D = {8{32'h0BAD_BEEF}};

  puf_sig_req_scheduler #(
    .NUM_REQ(NR), .CHALLENGE_SIZE(CS), .SIGN_SIZE(SS), .HELPER_DATA_SIZE(HS),
    .TIMEOUT_CYCLES(TO), .CLEAR_CYCLES(CC)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_helper(req_helper), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sig(rsp_sig), .rsp_err(rsp_err),
    .eng_addr(eng_addr), .eng_helper(eng_helper), .eng_load(eng_load),
    .eng_en(eng_en), .eng_done(eng_done), .eng_sig(eng_sig), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [HS-1:0] exp_helper(input int i);
    return {32'hBEEF_0000 + i, 32'hCAFE_0000 + i, 32'hF00D_0000 + i};
  endfunction

  function automatic logic [CS-1:0] exp_addr(input int i);
    return 32'h10 + i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [SS-1:0] obs, input logic [SS-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " req_ready"},  SS'(req_ready),  '0);
    chk({tag, " rsp_valid"},  SS'(rsp_valid),  '0);
    chk({tag, " rsp_id"},     SS'(rsp_id),     '0);
    chk({tag, " rsp_sig"},    rsp_sig,         '0);
    chk({tag, " rsp_err"},    SS'(rsp_err),    '0);
    chk({tag, " eng_addr"},   SS'(eng_addr),   '0);
    chk({tag, " eng_helper"}, SS'(eng_helper), '0);
    chk({tag, " eng_load"},   SS'(eng_load),   '0);
    chk({tag, " eng_en"},     SS'(eng_en),     '0);
    chk({tag, " busy"},       SS'(busy),       '0);
  endtask

  // Starts in IDLE with the winner's request pending and rsp_ready=1; ends in IDLE.
  task automatic run_job(input int id, input int run_cycles, input bit timeout,
                         input logic [SS-1:0] sig);
    chk("grant", SS'(req_ready), SS'(4'b0001 << id));
    tick();
    chk("load eng_load", SS'(eng_load), 1);
    chk("load eng_en", SS'(eng_en), 0);
    chk("load eng_addr", SS'(eng_addr), SS'(exp_addr(id)));
    chk("load eng_helper", SS'(eng_helper), SS'(exp_helper(id)));
    chk("load req_ready", SS'(req_ready), 0);
    tick();
    chk("run eng_en", SS'(eng_en), 1);
    if (timeout) begin
      repeat (TO - 1) tick();
      chk("run last rsp_valid", SS'(rsp_valid), 0);
      chk("run last eng_en", SS'(eng_en), 1);
    end else begin
      repeat (run_cycles - 1) tick();
      chk("run done-cycle eng_en", SS'(eng_en), 1);
      chk("run done-cycle rsp_valid", SS'(rsp_valid), 0);
      eng_done = 1'b1;
      eng_sig  = sig;
    end
    tick();
    eng_done = 1'b0;
    chk("resp rsp_valid", SS'(rsp_valid), 1);
    chk("resp rsp_id", SS'(rsp_id), SS'(id));
    chk("resp rsp_sig", rsp_sig, timeout ? '0 : sig);
    chk("resp rsp_err", SS'(rsp_err), SS'(timeout));
    chk("resp eng_load", SS'(eng_load), 1);
    chk("resp eng_en", SS'(eng_en), 0);
    tick();
    chk("clear rsp_valid", SS'(rsp_valid), 0);
    chk("clear eng_load", SS'(eng_load), 0);
    chk("clear req_ready", SS'(req_ready), 0);
    chk("clear busy", SS'(busy), 1);
    tick();
    chk("clear2 busy", SS'(busy), 1);
    tick();
    chk("idle busy", SS'(busy), 0);
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    eng_done = 1'b0;
    eng_sig = '0;
    req_addr = '0;
    req_helper = '0;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*CS +: CS]   = exp_addr(i);
      req_helper[i*HS +: HS] = exp_helper(i);
    end
    #1 rst = 1'b1;
    #3;
    chk_reset("reset");
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("idle no request ready", SS'(req_ready), 0);

    // Round robin with everyone asking continuously.
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    run_job(0, 3, 1'b0, SIG_B);
    run_job(1, 2, 1'b0, SIG_C);
    run_job(2, 1, 1'b0, SIG_D);
    run_job(3, 4, 1'b0, SIG_B);
    run_job(0, 2, 1'b0, SIG_C);

    // Single request, done 40 cycles into RUN.
    req_valid = 4'b0001;
    #1;
    run_job(0, 40, 1'b0, SIG_A);

    // Timeout on requester 2, then a normal job on requester 1.
    req_valid = 4'b0100;
    #1;
    run_job(2, 0, 1'b1, '0);
    req_valid = 4'b0010;
    #1;
    run_job(1, 5, 1'b0, SIG_B);

    // Backpressure on the response with another requester waiting.
    req_valid = 4'b1000;
    rsp_ready = 1'b0;
    #1;
    chk("bp grant", SS'(req_ready), SS'(4'b1000));
    tick();
    req_valid = 4'b0001;
    tick();
    tick();
    eng_done = 1'b1;
    eng_sig  = SIG_C;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp rsp_valid", SS'(rsp_valid), 1);
      chk("bp rsp_id", SS'(rsp_id), 3);
      chk("bp rsp_sig", rsp_sig, SIG_C);
      chk("bp eng_en", SS'(eng_en), 0);
      chk("bp eng_load", SS'(eng_load), 1);
      chk("bp req_ready", SS'(req_ready), 0);
      tick();
    end
    rsp_ready = 1'b1;
    eng_done = 1'b0;
    #1;
    chk("bp release rsp_valid", SS'(rsp_valid), 1);
    tick();
    chk("bp clear eng_load", SS'(eng_load), 0);
    chk("bp clear rsp_valid", SS'(rsp_valid), 0);
    tick();
    tick();
    chk("bp next grant", SS'(req_ready), SS'(4'b0001));

    // Sticky done keeps CLEAR open beyond the minimum.
    tick();
    tick();
    eng_done = 1'b1;
    eng_sig  = SIG_D;
    tick();
    chk("sticky rsp_sig", rsp_sig, SIG_D);
    chk("sticky rsp_id", SS'(rsp_id), 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("sticky clear busy", SS'(busy), 1);
      chk("sticky clear req_ready", SS'(req_ready), 0);
      chk("sticky clear eng_load", SS'(eng_load), 0);
      tick();
    end
    eng_done = 1'b0;
    #1;
    chk("sticky clear5 busy", SS'(busy), 1);
    tick();
    chk("sticky idle busy", SS'(busy), 0);
    chk("sticky regrant", SS'(req_ready), SS'(4'b0001));

    // Asynchronous reset in RUN; pointer must be restored.
    tick();
    req_valid = 4'b0101;
    tick();
    chk("pre-reset eng_en", SS'(eng_en), 1);
    tick();
    #2 rst = 1'b1;
    #1;
    chk_reset("async reset");
    tick();
    rst = 1'b0;
    #1;
    chk("post-reset grant", SS'(req_ready), SS'(4'b0001));
    tick();
    chk("post-reset eng_addr", SS'(eng_addr), SS'(exp_addr(0)));
    chk("post-reset eng_load", SS'(eng_load), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
